// File: rtl/btn_press_classifier.sv
// Conditions one raw button input (synchroniser + debouncer) and classifies
// each debounced press as short or long with single-cycle pulses.
module btn_press_classifier #(
  parameter int DB_CYCLES   = 1_000_000,
  parameter int LONG_CYCLES = 100_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_in,
  output logic held_o,
  output logic press_o,
  output logic short_o,
  output logic long_o
);

  localparam int DB_W   = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam int LONG_W = (LONG_CYCLES > 1) ? $clog2(LONG_CYCLES) : 1;
  localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DB_CYCLES - 1);
  localparam logic [LONG_W-1:0] LONG_LAST = LONG_W'(LONG_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    PRESSED   = 2'd1,
    LONG_HELD = 2'd2
  } state_t;

  logic              btn_p0;
  logic              btn_p1;
  logic              stable;
  logic [DB_W-1:0]   db_cnt;
  logic [LONG_W-1:0] hold_cnt;
  state_t            state;
  logic              db_accept;
  logic              rise_evt;
  logic              fall_evt;

  // Stage p0/p1: two-flop synchroniser for the asynchronous pin
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      btn_p0 <= 1'b0;
      btn_p1 <= 1'b0;
    end else begin
      btn_p0 <= btn_in;
      btn_p1 <= btn_p0;
    end
  end

  // Stage debounce: a new level must persist DB_CYCLES clocks to be accepted
  assign db_accept = (btn_p1 != stable) && (db_cnt == DB_LAST);
  assign rise_evt  = db_accept && btn_p1;
  assign fall_evt  = db_accept && !btn_p1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stable <= 1'b0;
      db_cnt <= '0;
    end else if (btn_p1 == stable) begin
      db_cnt <= '0;
    end else if (db_cnt == DB_LAST) begin
      stable <= btn_p1;
      db_cnt <= '0;
    end else begin
      db_cnt <= db_cnt + DB_W'(1);
    end
  end

  assign held_o = stable;

  // Stage classify: reacts on the same clock the debounced level changes,
  // so press_o lines up with the held_o edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      hold_cnt <= '0;
      press_o  <= 1'b0;
      short_o  <= 1'b0;
      long_o   <= 1'b0;
    end else begin
      press_o <= 1'b0;
      short_o <= 1'b0;
      long_o  <= 1'b0;
      case (state)
        IDLE: begin
          if (rise_evt) begin
            state    <= PRESSED;
            hold_cnt <= '0;
            press_o  <= 1'b1;
          end
        end
        PRESSED: begin
          // Release wins over reaching the long threshold on the same clock
          if (fall_evt) begin
            state   <= IDLE;
            short_o <= 1'b1;
          end else if (hold_cnt == LONG_LAST) begin
            state  <= LONG_HELD;
            long_o <= 1'b1;
          end else begin
            hold_cnt <= hold_cnt + LONG_W'(1);
          end
        end
        LONG_HELD: begin
          if (fall_evt) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_btn_press_classifier.sv
// Directed and randomized bench for btn_press_classifier, checked every cycle
// against a history-window reference model of debounce and press timing.
module tb_btn_press_classifier;

  localparam int DB   = 4;
  localparam int LONG = 20;

  logic clk    = 1'b0;
  logic rst    = 1'b1;
  logic btn_in = 1'b1;
  logic held_o, press_o, short_o, long_o;

  btn_press_classifier #(.DB_CYCLES(DB), .LONG_CYCLES(LONG)) dut (
    .clk    (clk),
    .rst    (rst),
    .btn_in (btn_in),
    .held_o (held_o),
    .press_o(press_o),
    .short_o(short_o),
    .long_o (long_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;
  int fails  = 0;

  // Reference model: btn samples since reset, expected outputs per edge
  bit hist[$];
  int n;
  bit m_stable, m_pressing, m_long_done;
  int m_press_edge;
  bit e_press, e_short, e_long;

  // Observed DUT pulses (edge numbers since reset, cumulative counts)
  int last_press, last_short, last_long;
  int cnt_press = 0, cnt_short = 0, cnt_long = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic bit seen(int m);
    // The debouncer at edge m sees the pin value sampled two edges earlier
    if (m < 3) return 1'b0;
    return hist[m-3];
  endfunction

  task automatic model_reset();
    hist.delete();
    n = 0;
    m_stable = 0; m_pressing = 0; m_long_done = 0; m_press_edge = 0;
    e_press = 0; e_short = 0; e_long = 0;
    last_press = -1; last_short = -1; last_long = -1;
  endtask

  task automatic model_edge(input bit b);
    bit flip;
    n++;
    hist.push_back(b);
    e_press = 0; e_short = 0; e_long = 0;
    flip = 1'b1;
    for (int j = 0; j < DB; j++)
      if (seen(n - j) == m_stable) flip = 1'b0;
    if (flip) begin
      m_stable = !m_stable;
      if (m_stable) begin
        e_press = 1; m_pressing = 1; m_long_done = 0; m_press_edge = n;
      end else begin
        if (m_pressing && !m_long_done && (n - m_press_edge) <= LONG) e_short = 1;
        m_pressing = 0;
      end
    end else if (m_pressing && !m_long_done && (n - m_press_edge) == LONG) begin
      e_long = 1; m_long_done = 1;
    end
  endtask

  task automatic cycle(input logic b);
    btn_in = b;
    @(posedge clk);
    if (rst) model_edge(b);
    #1;
    chk("held_o",  held_o,  m_stable);
    chk("press_o", press_o, e_press);
    chk("short_o", short_o, e_short);
    chk("long_o",  long_o,  e_long);
    if (press_o === 1'b1) begin cnt_press++; last_press = n; end
    if (short_o === 1'b1) begin cnt_short++; last_short = n; end
    if (long_o  === 1'b1) begin cnt_long++;  last_long  = n; end
  endtask

  task automatic cycles(input logic b, input int count);
    for (int i = 0; i < count; i++) cycle(b);
  endtask

  int lc, cp, cs, cl;
  bit lvl;

  initial begin
    model_reset();

    // 1: reset asserted with the button high; everything stays 0
    #1 rst = 1'b0;
    #1;
    chk("rst_held",  held_o,  1'b0);
    chk("rst_press", press_o, 1'b0);
    cycles(1'b1, 6);
    cycles(1'b0, 2);
    rst = 1'b1;
    cycles(1'b0, 4);

    // 2: bounce every 2 clocks for 20 clocks, then settle high
    cp = cnt_press;
    for (int i = 0; i < 5; i++) begin
      cycles(1'b1, 2);
      cycles(1'b0, 2);
    end
    lc = n;
    cycles(1'b1, 6);
    chk("bounce_press_count", cnt_press - cp, 1);
    chk("bounce_rise_latency", last_press - lc, 6);
    chk("bounce_held", held_o, 1'b1);

    // 3: short press
    cycles(1'b1, 10);
    lc = n; cs = cnt_short; cl = cnt_long;
    cycles(1'b0, 8);
    chk("short_count", cnt_short - cs, 1);
    chk("short_latency", last_short - lc, 6);
    chk("short_no_long", cnt_long - cl, 0);

    // 4: long press
    cs = cnt_short; cl = cnt_long;
    cycles(1'b1, 40);
    chk("long_count", cnt_long - cl, 1);
    chk("long_after_press", last_long - last_press, LONG);
    cycles(1'b0, 8);
    chk("long_no_short", cnt_short - cs, 0);
    chk("long_released", held_o, 1'b0);

    // 5: release lands on the threshold clock
    cs = cnt_short; cl = cnt_long;
    cycles(1'b1, 6);
    chk("bnd_press_now", last_press, n);
    cycles(1'b1, 14);
    cycles(1'b0, 6);
    chk("bnd_short", last_short - last_press, LONG);
    chk("bnd_short_count", cnt_short - cs, 1);
    chk("bnd_no_long", cnt_long - cl, 0);
    cycles(1'b0, 4);

    // 6: reset mid-hold, button still high on release
    cycles(1'b1, 6);
    cycles(1'b1, 10);
    chk("mid_held_before", held_o, 1'b1);
    cs = cnt_short; cl = cnt_long;
    #2 rst = 1'b0;
    #1;
    chk("async_held", held_o,  1'b0);
    chk("async_press", press_o, 1'b0);
    chk("async_short", short_o, 1'b0);
    chk("async_long", long_o,  1'b0);
    model_reset();
    cycles(1'b1, 5);
    rst = 1'b1;
    cycles(1'b1, 6);
    chk("rst_fresh_press", last_press, 6);
    chk("rst_no_short", cnt_short - cs, 0);
    chk("rst_no_long_yet", cnt_long - cl, 0);
    cycles(1'b1, 20);
    chk("rst_long_after_press", last_long - last_press, LONG);
    cycles(1'b0, 8);

    // Randomized run lengths, including glitches and long holds
    lvl = 1'b0;
    for (int k = 0; k < 120; k++) begin
      lvl = !lvl;
      cycles(lvl, $urandom_range(1, 30));
    end
    cycles(1'b0, 10);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
